// File: rtl/eq_lock_detect_amisha.sv
// eq_lock_detect_amisha: 2-bit equality checker with run/total match counters and a lock FSM with hysteresis
module eq_lock_detect_amisha #(
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2
) (
    input  logic       clk_amisha,
    input  logic       rst_n_amisha,
    input  logic [1:0] a_amisha,
    input  logic [1:0] b_amisha,
    input  logic       in_valid_amisha,
    input  logic       clr_amisha,
    output logic       match_amisha,
    output logic       out_valid_amisha,
    output logic [3:0] run_cnt_amisha,
    output logic [7:0] total_cnt_amisha,
    output logic       lock_amisha
);
    typedef enum logic [1:0] {SEARCH, LOCKED, LOSING} state_t;
    localparam logic [3:0] LOCK_V   = 4'(LOCK_N);
    localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_N);
    state_t     state_q, state_d;
    logic [3:0] miss_q, miss_d, run_q, run_d;
    logic [7:0] total_q, total_d;
    logic       match_q, match_d, out_valid_q, out_valid_d, lock_q, lock_d, eq;
    always_comb begin
        eq          = &(a_amisha ~^ b_amisha);
        state_d     = state_q;
        miss_d      = miss_q;
        run_d       = run_q;
        total_d     = total_q;
        match_d     = match_q;
        out_valid_d = 1'b0;
        if (clr_amisha) begin
            state_d = SEARCH;
            miss_d  = '0;
            run_d   = '0;
            total_d = '0;
            match_d = 1'b0;
        end else if (in_valid_amisha) begin
            out_valid_d = 1'b1;
            match_d     = eq;
            if (eq) begin
                run_d   = (&run_q) ? run_q : run_q + 4'd1;
                total_d = (&total_q) ? total_q : total_q + 8'd1;
                miss_d  = '0;
                state_d = (state_q != SEARCH || run_d >= LOCK_V) ? LOCKED : SEARCH;
            end else begin
                run_d   = '0;
                miss_d  = (state_q == SEARCH) ? 4'd0 : miss_q + 4'd1;
                state_d = (state_q == SEARCH || miss_d >= UNLOCK_V) ? SEARCH : LOSING;
                miss_d  = (state_d == SEARCH) ? 4'd0 : miss_d;
            end
        end
        lock_d = (state_d != SEARCH);
    end
    always_ff @(posedge clk_amisha) begin
        if (!rst_n_amisha) begin
            state_q     <= SEARCH;
            miss_q      <= '0;
            run_q       <= '0;
            total_q     <= '0;
            match_q     <= 1'b0;
            out_valid_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_q      <= miss_d;
            run_q       <= run_d;
            total_q     <= total_d;
            match_q     <= match_d;
            out_valid_q <= out_valid_d;
            lock_q      <= lock_d;
        end
    end
    assign match_amisha     = match_q;
    assign out_valid_amisha = out_valid_q;
    assign run_cnt_amisha   = run_q;
    assign total_cnt_amisha = total_q;
    assign lock_amisha      = lock_q;
endmodule

// File: doc/eq_lock_detect_amisha.md
EQ_LOCK_DETECT_AMISHA -- requirements
Module: eq_lock_detect_amisha

Interface
REQ-001 Parameter: LOCK_N, default 4, number of consecutive valid matches required to assert lock (legal 1..15).
REQ-002 Parameter: UNLOCK_N, default 2, number of consecutive valid mismatches required to drop lock (legal 1..15).
REQ-003 Port: clk_amisha  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n_amisha  input  1  synchronous, active-low reset.
REQ-005 Port: a_amisha  input  2  received sample.
REQ-006 Port: b_amisha  input  2  expected sample.
REQ-007 Port: in_valid_amisha  input  1  a_amisha/b_amisha hold a sample this cycle.
REQ-008 Port: clr_amisha  input  1  synchronous clear of counters and FSM.
REQ-009 Port: match_amisha  output  1  registered result of the 2-bit equality of the last valid sample.
REQ-010 Port: out_valid_amisha  output  1  one-cycle pulse; match_amisha and the counters reflect a newly accepted sample.
REQ-011 Port: run_cnt_amisha  output  4  consecutive-match count, saturating at 15.
REQ-012 Port: total_cnt_amisha  output  8  total matches since reset/clear, saturating at 255.
REQ-013 Port: lock_amisha  output  1  lock indication.

Function
REQ-014 Equality SHALL be bitwise: eq = (a[1]~^b[1]) & (a[0]~^b[0]), evaluated only when in_valid_amisha=1.
REQ-015 Latency SHALL be 1 cycle: a sample accepted at edge N updates all outputs, visible after edge N; out_valid_amisha=1 for exactly that cycle.
REQ-016 With in_valid_amisha=0 and clr_amisha=0, every output except out_valid_amisha (driven 0) SHALL hold its value.
REQ-017 On a valid match: run_cnt +1 (saturating at 15), total_cnt +1 (saturating at 255).
REQ-018 On a valid mismatch: run_cnt SHALL be set to 0; total_cnt SHALL hold.
REQ-019 The FSM SHALL have three states: SEARCH (lock=0), LOCKED (lock=1), LOSING (lock=1); an internal miss counter counts consecutive mismatches.
REQ-020 SEARCH->LOCKED on a valid match when the post-update run_cnt >= LOCK_N; lock_amisha rises on that same edge.
REQ-021 LOCKED->LOSING on a valid mismatch with miss=1; if UNLOCK_N=1, it SHALL instead go LOCKED->SEARCH directly.
REQ-022 In LOSING, a valid mismatch increments miss; when miss reaches UNLOCK_N, the FSM goes to SEARCH with lock=0 and miss=0.
REQ-023 In LOSING, a valid match returns to LOCKED with miss=0.
REQ-024 Samples with in_valid_amisha=0 SHALL NOT advance the FSM, the counters or miss (gaps are transparent).
REQ-025 clr_amisha=1 SHALL take priority over in_valid_amisha: the sample that cycle is discarded; run_cnt, total_cnt, miss, match and out_valid are set to 0; the FSM goes to SEARCH.
REQ-026 At saturation, run_cnt SHALL stay 15 and total_cnt SHALL stay 255 on further matches; there is no wrap-around.

Reset
REQ-027 rst_n_amisha=0 at a rising edge SHALL force: match=0, out_valid=0, run_cnt=0, total_cnt=0, lock=0, FSM=SEARCH, miss=0.
REQ-028 Reset SHALL take priority over clr_amisha and in_valid_amisha, including mid-lock and mid-LOSING.
REQ-029 Asserting reset without a clock edge SHALL have no effect.

Verification
REQ-030 Defaults; 4 consecutive valid samples a=b=2'b10 -> run_cnt 1,2,3,4; lock rises after the 4th edge; total_cnt=4.
REQ-031 Locked, then valid a=01/b=00, then valid a=b=11 -> LOSING (lock stays 1, run_cnt=0), then LOCKED (run_cnt=1).
REQ-032 Locked, then 2 consecutive valid mismatches separated by 3 in_valid=0 cycles -> lock falls only after the 2nd mismatch; out_valid pulses exactly twice.
REQ-033 300 consecutive valid matches -> run_cnt stays 15 from the 15th sample; total_cnt stays 255 from the 255th sample; lock remains 1.
REQ-034 clr_amisha and a valid match in the same cycle while locked -> all counters 0, lock=0, out_valid=0 next cycle.
REQ-035 rst_n_amisha=0 for one edge during LOSING with a valid sample present -> all outputs at reset values; next match gives run_cnt=1.
